// File: rtl/chip8_framebuffer.sv
// rtl/chip8_framebuffer.sv - 64x32 1bpp Chip-8 display store with clear and XOR sprite draw
module chip8_framebuffer #(
    parameter int WRAP = 0,
    parameter int FB_W = 64,
    parameter int FB_H = 32
) (
    input  logic        clk50,
    input  logic        reset,
    input  logic [10:0] fb_request_addr,
    output logic        fb_pixel_data,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_x,
    input  logic [7:0]  cmd_y,
    input  logic [3:0]  cmd_n,
    output logic        row_req,
    output logic [3:0]  row_idx,
    input  logic        row_valid,
    input  logic [7:0]  row_data,
    output logic        busy,
    output logic        done,
    output logic        collision
);

    localparam bit WRAP_EN = (WRAP != 0);

    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_DRAW  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [FB_W-1:0] pix [FB_H];
    logic            rd_q;
    logic [4:0]      clr_row;
    logic [5:0]      x_q;
    logic [4:0]      y_q;
    logic [3:0]      n_q;
    logic [3:0]      idx_q;
    logic [7:0]      data_q;
    logic            coll_q;

    logic [5:0]      tgt_sum;
    logic [4:0]      tgt_row;
    logic            row_hit;
    logic [FB_W-1:0] mask;
    logic [FB_W-1:0] old_row;
    logic            hit;
    logic            last_row;

    // Target row and column mask of the sprite row held in data_q.
    always_comb begin
        tgt_sum = {1'b0, y_q} + {2'b00, idx_q};
        tgt_row = tgt_sum[4:0];
        row_hit = WRAP_EN || !tgt_sum[5];
        mask    = '0;
        for (int i = 0; i < 8; i++) begin
            logic [6:0] col_sum;
            col_sum = {1'b0, x_q} + 7'(7 - i);
            if (data_q[i] && (WRAP_EN || !col_sum[6])) begin
                mask[col_sum[5:0]] = 1'b1;
            end
        end
        old_row  = pix[tgt_row];
        hit      = row_hit && (|(mask & old_row));
        last_row = (idx_q == n_q - 4'd1);
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_CLEAR: state_n = S_CLEAR;
                        OP_DRAW:  state_n = (cmd_n == 4'd0) ? S_DONE : S_FETCH;
                        default:  state_n = S_DONE;
                    endcase
                end
            end
            S_CLEAR: begin
                if (clr_row == 5'd31) begin
                    state_n = S_DONE;
                end
            end
            S_FETCH: begin
                if (row_valid) begin
                    state_n = S_WRITE;
                end
            end
            S_WRITE: state_n = last_row ? S_DONE : S_FETCH;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state   <= S_IDLE;
            rd_q    <= 1'b0;
            clr_row <= '0;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            coll_q  <= 1'b0;
            for (int r = 0; r < FB_H; r++) begin
                pix[r] <= '0;
            end
        end else begin
            state <= state_n;
            // Nonblocking read gives the pre-write value on a same-edge write.
            rd_q  <= pix[fb_request_addr[10:6]][fb_request_addr[5:0]];
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        clr_row <= '0;
                        if (cmd_op == OP_DRAW) begin
                            x_q    <= 6'(cmd_x % 8'd64);
                            y_q    <= 5'(cmd_y % 8'd32);
                            n_q    <= cmd_n;
                            idx_q  <= '0;
                            coll_q <= 1'b0;
                        end
                    end
                end
                S_CLEAR: begin
                    pix[clr_row] <= '0;
                    clr_row      <= clr_row + 5'd1;
                end
                S_FETCH: begin
                    if (row_valid) begin
                        data_q <= row_data;
                    end
                end
                S_WRITE: begin
                    if (row_hit) begin
                        pix[tgt_row] <= old_row ^ mask;
                        coll_q       <= coll_q | hit;
                    end
                    if (!last_row) begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fb_pixel_data = rd_q;
    assign cmd_ready     = (state == S_IDLE);
    assign busy          = ~cmd_ready;
    assign row_req       = (state == S_FETCH);
    assign row_idx       = idx_q;
    assign done          = (state == S_DONE);
    assign collision     = coll_q;

endmodule

// File: tb/tb_chip8_framebuffer.sv
// tb/tb_chip8_framebuffer.sv - random-stimulus bench for chip8_framebuffer, clipped and wrapping builds
module tb_chip8_framebuffer;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] fb_request_addr = '0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [7:0]  cmd_x = '0;
    logic [7:0]  cmd_y = '0;
    logic [3:0]  cmd_n = '0;
    logic        row_valid = 1'b0;
    logic [7:0]  row_data = '0;

    logic        fb_pixel_data0, cmd_ready0, row_req0, busy0, done0, collision0;
    logic [3:0]  row_idx0;
    logic        fb_pixel_data1, cmd_ready1, row_req1, busy1, done1, collision1;
    logic [3:0]  row_idx1;

    always #5 clk50 = ~clk50;

    chip8_framebuffer #(.WRAP(0)) dut_clip (
        .clk50(clk50), .reset(reset), .fb_request_addr(fb_request_addr),
        .fb_pixel_data(fb_pixel_data0), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n),
        .row_req(row_req0), .row_idx(row_idx0), .row_valid(row_valid), .row_data(row_data),
        .busy(busy0), .done(done0), .collision(collision0)
    );

    chip8_framebuffer #(.WRAP(1)) dut_wrap (
        .clk50(clk50), .reset(reset), .fb_request_addr(fb_request_addr),
        .fb_pixel_data(fb_pixel_data1), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_n(cmd_n),
        .row_req(row_req1), .row_idx(row_idx1), .row_valid(row_valid), .row_data(row_data),
        .busy(busy1), .done(done1), .collision(collision1)
    );

    int errors = 0;
    int checks = 0;

    // Reference screens: index 0 clips, index 1 wraps.
    bit          m [2][32][64];
    bit          coll [2];
    logic        exp_pix0 = 1'b0;
    logic        exp_pix1 = 1'b0;
    bit          manual = 1'b1;
    logic [10:0] man_addr = '0;
    bit          chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk50) begin
        if (reset) begin
            exp_pix0 <= 1'b0;
            exp_pix1 <= 1'b0;
        end else begin
            exp_pix0 <= m[0][fb_request_addr[10:6]][fb_request_addr[5:0]];
            exp_pix1 <= m[1][fb_request_addr[10:6]][fb_request_addr[5:0]];
        end
    end

    always @(posedge clk50) begin
        #1;
        fb_request_addr = manual ? man_addr : 11'($urandom);
    end

    always @(negedge clk50) begin
        if (chk_on) begin
            chk("pixel_clip", fb_pixel_data0, exp_pix0);
            chk("pixel_wrap", fb_pixel_data1, exp_pix1);
            chk("busy_clip", busy0, !cmd_ready0);
            chk("busy_wrap", busy1, !cmd_ready1);
        end
    end

    task automatic tick;
        @(posedge clk50);
        #2;
    endtask

    task automatic zero_model;
        for (int w = 0; w < 2; w++)
            for (int r = 0; r < 32; r++)
                for (int c = 0; c < 64; c++)
                    m[w][r][c] = 1'b0;
    endtask

    task automatic apply(input int w, input int x, input int y, input int k, input logic [7:0] d);
        int r, c;
        r = (y % 32) + k;
        if (r >= 32) begin
            if (w == 0) return;
            r -= 32;
        end
        for (int j = 0; j < 8; j++) begin
            c = (x % 64) + j;
            if (c >= 64) begin
                if (w == 0) continue;
                c -= 64;
            end
            if (d[7-j]) begin
                if (m[w][r][c]) coll[w] = 1'b1;
                m[w][r][c] = ~m[w][r][c];
            end
        end
    endtask

    task automatic draw(input int x, input int y, input int n, input logic [7:0] rows [16],
                        input int stall_max, input bit stall5);
        int st;
        chk("ready_before_draw", cmd_ready0, 1);
        cmd_valid = 1'b1; cmd_op = 2'b10;
        cmd_x = 8'(x); cmd_y = 8'(y); cmd_n = 4'(n);
        tick;
        cmd_valid = 1'b0; cmd_x = 8'($urandom); cmd_y = 8'($urandom); cmd_n = 4'($urandom);
        coll[0] = 1'b0; coll[1] = 1'b0;
        for (int k = 0; k < n; k++) begin
            st = stall5 ? 5 : int'($urandom_range(stall_max, 0));
            for (int s = 0; s < st; s++) begin
                row_valid = 1'b0;
                chk("stall_row_req", row_req0, 1);
                chk("stall_row_idx", row_idx0, k);
                chk("stall_no_done", done0, 0);
                tick;
            end
            chk("fetch_row_req", row_req0, 1);
            chk("fetch_row_idx", row_idx0, k);
            row_valid = 1'b1; row_data = rows[k];
            tick;
            row_valid = 1'($urandom); row_data = 8'($urandom);
            chk("row_req_drop", row_req0, 0);
            chk("write_no_done", done0, 0);
            tick;
            row_valid = 1'b0;
            apply(0, x, y, k, rows[k]);
            apply(1, x, y, k, rows[k]);
        end
        chk("draw_done_clip", done0, 1);
        chk("draw_done_wrap", done1, 1);
        chk("draw_ready_low", cmd_ready0, 0);
        chk("collision_clip", collision0, coll[0]);
        chk("collision_wrap", collision1, coll[1]);
        tick;
        chk("done_one_cycle", done0, 0);
        chk("ready_after_draw", cmd_ready0, 1);
    endtask

    task automatic noop;
        chk("ready_before_noop", cmd_ready0, 1);
        cmd_valid = 1'b1; cmd_op = ($urandom & 1) ? 2'b11 : 2'b00;
        tick;
        cmd_valid = 1'b0;
        chk("noop_done", done0, 1);
        chk("noop_coll_clip", collision0, coll[0]);
        chk("noop_coll_wrap", collision1, coll[1]);
        tick;
        chk("noop_idle", cmd_ready0, 1);
    endtask

    task automatic clear_screen(input bit poke);
        chk("ready_before_clear", cmd_ready0, 1);
        cmd_valid = 1'b1; cmd_op = 2'b01;
        tick;
        cmd_valid = 1'b0;
        for (int r = 0; r < 32; r++) begin
            chk("clear_busy", cmd_ready0, 0);
            chk("clear_no_done", done0, 0);
            if (poke && r >= 4 && r < 8) begin
                cmd_valid = 1'b1; cmd_op = 2'b10; cmd_n = 4'd1;
            end else begin
                cmd_valid = 1'b0;
            end
            tick;
            for (int w = 0; w < 2; w++)
                for (int c = 0; c < 64; c++)
                    m[w][r][c] = 1'b0;
        end
        cmd_valid = 1'b0;
        chk("clear_done_33", done0, 1);
        chk("clear_coll_clip", collision0, coll[0]);
        chk("clear_coll_wrap", collision1, coll[1]);
        tick;
        chk("clear_idle", cmd_ready0, 1);
        chk("clear_done_drop", done0, 0);
        tick;
        chk("no_queued_cmd", cmd_ready0, 1);
    endtask

    task automatic rd(input int a, input logic e0, input logic e1);
        manual = 1'b1;
        man_addr = 11'(a);
        tick;
        tick;
        chk("literal_clip", fb_pixel_data0, e0);
        chk("literal_wrap", fb_pixel_data1, e1);
    endtask

    task automatic scan_zero;
        for (int a = 0; a < 2048; a++) rd(a, 1'b0, 1'b0);
    endtask

    logic [7:0] rows [16];

    initial begin
        reset = 1'b1;
        tick;
        chk_on = 1'b1;
        tick;
        chk("reset_ready", cmd_ready0, 1);
        chk("reset_row_req", row_req0, 0);
        chk("reset_row_idx", row_idx0, 0);
        chk("reset_done", done0, 0);
        chk("reset_collision", collision0, 0);
        chk("reset_pixel", fb_pixel_data0, 0);
        reset = 1'b0;
        tick;
        scan_zero;

        for (int i = 0; i < 16; i++) rows[i] = 8'h00;
        rows[0] = 8'hF0;
        draw(0, 0, 1, rows, 0, 1'b0);
        chk("first_draw_coll", collision0, 0);
        rd(0, 1, 1); rd(3, 1, 1); rd(4, 0, 0);
        draw(0, 0, 1, rows, 0, 1'b0);
        chk("redraw_coll", collision0, 1);
        rd(0, 0, 0); rd(3, 0, 0);

        rows[0] = 8'hC0; rows[1] = 8'hFF;
        draw(62, 31, 2, rows, 0, 1'b0);
        rd(2046, 1, 1); rd(2047, 1, 1);
        rd(62, 0, 1); rd(0, 0, 1); rd(5, 0, 1); rd(6, 0, 0);
        chk("wrap_draw_coll", collision1, 0);

        for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
        draw(20, 10, 3, rows, 0, 1'b1);

        manual = 1'b0;
        for (int t = 0; t < 40; t++) begin
            int sel;
            sel = int'($urandom_range(9, 0));
            if (sel == 0) noop;
            else if (sel == 1) clear_screen(1'b0);
            else begin
                for (int i = 0; i < 16; i++) rows[i] = 8'($urandom);
                draw(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                     int'($urandom_range(15, 0)), rows, 2, 1'b0);
            end
        end
        manual = 1'b1;

        clear_screen(1'b0);
        for (int i = 0; i < 16; i++) rows[i] = 8'hFF;
        for (int x = 0; x < 64; x += 8) begin
            draw(x, 0, 15, rows, 0, 1'b0);
            draw(x, 15, 15, rows, 0, 1'b0);
            draw(x, 30, 2, rows, 0, 1'b0);
        end
        rd(0, 1, 1); rd(2047, 1, 1);
        rows[0] = 8'h01;
        draw(0, 0, 1, rows, 0, 1'b0);
        chk("fill_overlap_coll", collision0, 1);
        clear_screen(1'b1);
        chk("clear_keeps_coll", collision0, 1);
        scan_zero;

        for (int i = 0; i < 16; i++) rows[i] = 8'hFF;
        chk("ready_before_abort", cmd_ready0, 1);
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_x = 8'd3; cmd_y = 8'd3; cmd_n = 4'd3;
        tick;
        cmd_valid = 1'b0;
        row_valid = 1'b1; row_data = 8'hFF;
        tick;
        row_valid = 1'b0;
        reset = 1'b1;
        tick;
        zero_model;
        coll[0] = 1'b0; coll[1] = 1'b0;
        chk("abort_ready", cmd_ready0, 1);
        chk("abort_no_done", done0, 0);
        chk("abort_row_req", row_req0, 0);
        chk("abort_row_idx", row_idx0, 0);
        chk("abort_collision", collision0, 0);
        reset = 1'b0;
        tick;
        chk("abort_still_no_done", done0, 0);
        chk("abort_idle", cmd_ready0, 1);
        scan_zero;

        rows[0] = 8'h80;
        draw(200, 40, 1, rows, 0, 1'b0);
        rd(520, 1, 1); rd(519, 0, 0); rd(521, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
